// File: rtl/a0_monitor.sv
// Watches the register-file a0 output and queues every change, tagged with a
// cycle timestamp, in a small FIFO drained over a valid/ready handshake.
module a0_monitor #(
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [31:0]              a0,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]     r_mem_data [DEPTH];
    logic [TS_W-1:0] r_mem_ts   [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [LW-1:0]   r_level;
    logic [TS_W-1:0] r_ts;
    logic [31:0]     r_last;
    logic            r_first;
    logic            r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic w_event;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign out_valid = (r_level != '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_pop     = out_valid & out_ready;
    assign w_event   = en & (r_first | (a0 != r_last));
    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
    assign w_push    = w_event & (~w_full | w_pop);
    assign w_drop    = w_event & w_full & ~w_pop;

    assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_ts    = out_valid ? r_mem_ts[r_rd_ptr]   : '0;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= a0;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_ts       <= '0;
            r_last     <= '0;
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);

            // last advances even on a drop so an unchanged value is not re-reported
            if (w_event) begin
                r_last  <= a0;
                r_first <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (clr) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {DROP_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_a0_monitor.sv
// Bench for a0_monitor: hand-computed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_a0_monitor;

    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int DROP_W = 8;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [31:0]       a0;
    logic              clr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [TS_W-1:0]   out_ts;
    logic [3:0]        level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int checks;
    int failures;

    a0_monitor #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a0(a0), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ts(out_ts), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [31:0] a0;
        logic        clr;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] et;
        logic [3:0]  el;
        logic        eo;
        logic [7:0]  edc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [15:0] ts;
    } entry_t;

    vec_t vecs[$];

    // Reference model: the FIFO as a queue, plus the capture rules stated plainly
    entry_t      mq[$];
    logic [15:0] mTs;
    logic [31:0] mLast;
    logic        mFirst;
    logic        mOv;
    int          mDc;

    task automatic addVec(input logic r, input logic e, input logic [31:0] d, input logic c,
                          input logic rd, input logic ev, input logic [31:0] ed,
                          input logic [15:0] et, input logic [3:0] el, input logic eo,
                          input logic [7:0] edc);
        vec_t v;
        v = '{r, e, d, c, rd, ev, ed, et, el, eo, edc};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [31:0] d,
                                 input logic c, input logic rd);
        rst_n     = r;
        en        = e;
        a0        = d;
        clr       = c;
        out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelStep(input logic r, input logic e, input logic [31:0] d,
                             input logic c, input logic rd);
        logic   pop;
        entry_t ent;
        if (!r) begin
            mq.delete();
            mTs    = 0;
            mLast  = 0;
            mFirst = 1'b1;
            mOv    = 1'b0;
            mDc    = 0;
            return;
        end
        pop = (mq.size() != 0) && rd;
        if (pop) void'(mq.pop_front());
        if (e && (mFirst || d != mLast)) begin
            mLast  = d;
            mFirst = 1'b0;
            if (mq.size() < DEPTH) begin
                ent.data = d;
                ent.ts   = mTs;
                mq.push_back(ent);
            end else begin
                mOv = 1'b1;
                if (mDc < 255) mDc++;
            end
        end
        if (c) begin
            mOv = 1'b0;
            mDc = 0;
        end
        mTs = mTs + 16'd1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        a0        = '0;
        clr       = 1'b0;
        out_ready = 1'b0;

        // Table: reset, constant zero, the 5,5,7,7,7,9 pattern, overflow, full push+pop, clr vs drop, drain
        addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        addVec(1, 1, 0, 0, 1,  1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) addVec(1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        addVec(1, 1, 5, 0, 1,  1, 5, 5, 1, 0, 0);
        addVec(1, 1, 5, 0, 1,  0, 0, 0, 0, 0, 0);
        addVec(1, 1, 7, 0, 1,  1, 7, 7, 1, 0, 0);
        addVec(1, 1, 7, 0, 1,  0, 0, 0, 0, 0, 0);
        addVec(1, 1, 7, 0, 1,  0, 0, 0, 0, 0, 0);
        addVec(1, 1, 9, 0, 1,  1, 9, 10, 1, 0, 0);
        addVec(1, 1, 9, 0, 1,  0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) addVec(1, 1, k, 0, 0,  1, 1, 12, 4'(k), 0, 0);
        addVec(1, 1, 9, 0, 0,  1, 1, 12, 8, 1, 1);
        addVec(1, 1, 10, 0, 0, 1, 1, 12, 8, 1, 2);
        addVec(1, 1, 11, 0, 1, 1, 2, 13, 8, 1, 2);
        addVec(1, 1, 12, 1, 0, 1, 2, 13, 8, 0, 0);
        for (int k = 3; k <= 8; k++) addVec(1, 1, 12, 0, 1,  1, k, 16'(k + 11), 4'(10 - k), 0, 0);
        addVec(1, 1, 12, 0, 1, 1, 11, 22, 1, 0, 0);
        addVec(1, 1, 12, 0, 1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].a0, vecs[i].clr, vecs[i].rdy);
            checkOutput($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            checkOutput($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].el));
            checkOutput($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].eo));
            checkOutput($sformatf("v%0d_drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].edc));
            if (vecs[i].ev || !vecs[i].rst_n) begin
                checkOutput($sformatf("v%0d_data", i), out_data, vecs[i].ed);
                checkOutput($sformatf("v%0d_ts", i), 32'(out_ts), 32'(vecs[i].et));
            end
        end

        // Mid-stream reset with four queued entries, then recapture of the same value
        for (int k = 0; k < 4; k++) applyStimulus(1, 1, 32'(20 + k), 0, 0);
        checkOutput("pre_reset_level", 32'(level), 4);
        applyStimulus(0, 1, 23, 0, 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_ts", 32'(out_ts), 0);
        applyStimulus(1, 1, 23, 0, 0);
        checkOutput("first_valid", 32'(out_valid), 1);
        checkOutput("first_data", out_data, 23);
        checkOutput("first_ts", 32'(out_ts), 0);

        // Drop counter saturation: 7 more pushes fill the FIFO, 263 drops exceed 255
        for (int k = 0; k < 270; k++) applyStimulus(1, 1, 32'(100 + k), 0, 0);
        checkOutput("sat_level", 32'(level), 8);
        checkOutput("sat_overflow", 32'(overflow), 1);
        checkOutput("sat_drop_cnt", 32'(drop_cnt), 255);
        checkOutput("sat_head", out_data, 23);
        applyStimulus(1, 1, 369, 1, 0);
        checkOutput("clr_overflow", 32'(overflow), 0);
        checkOutput("clr_drop_cnt", 32'(drop_cnt), 0);
        checkOutput("clr_level", 32'(level), 8);

        // Disabled capture while draining; re-enable with the held last value, then a new one
        for (int k = 0; k < 8; k++) applyStimulus(1, 0, 32'(500 + k), 0, 1);
        checkOutput("en0_level", 32'(level), 0);
        checkOutput("en0_valid", 32'(out_valid), 0);
        applyStimulus(1, 1, 369, 0, 1);
        checkOutput("reen_same_level", 32'(level), 0);
        applyStimulus(1, 1, 5, 0, 1);
        checkOutput("reen_new_valid", 32'(out_valid), 1);
        checkOutput("reen_new_data", out_data, 5);
        checkOutput("reen_new_ts", 32'(out_ts), 281);

        // Randomized run against the reference model
        modelStep(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic        r, e, c, rd;
            logic [31:0] d;
            int          rdyPct;
            rdyPct = ((i / 300) % 2 == 0) ? 30 : 80;
            r  = ($urandom_range(0, 299) != 0);
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 59) == 0);
            rd = ($urandom_range(0, 99) < rdyPct);
            d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            modelStep(r, e, d, c, rd);
            applyStimulus(r, e, d, c, rd);
            checkOutput($sformatf("r%0d_valid", i), 32'(out_valid), 32'(mq.size() != 0));
            checkOutput($sformatf("r%0d_level", i), 32'(level), 32'(mq.size()));
            checkOutput($sformatf("r%0d_overflow", i), 32'(overflow), 32'(mOv));
            checkOutput($sformatf("r%0d_drop_cnt", i), 32'(drop_cnt), 32'(mDc));
            if (mq.size() != 0) begin
                checkOutput($sformatf("r%0d_data", i), out_data, mq[0].data);
                checkOutput($sformatf("r%0d_ts", i), 32'(out_ts), 32'(mq[0].ts));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a0_monitor.md
Name: a0_monitor

Overview:
- Observer on the a0 output of the CPU register file (x10, the program's result/display register).
- Samples a0 every rising clk edge and detects changes. Each new value is pushed, with a cycle timestamp, into a small FIFO.
- The testbench/display side drains the FIFO over a valid/ready interface, so no a0 transition is lost when the consumer stalls.
- Register file writes land on the falling edge, so a0 is stable at every rising edge.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- TS_W, 16, timestamp width in bits.
- DROP_W, 8, dropped-event counter width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  capture enable; when 0, no change events are generated
- a0  in  32  register file a0 value
- clr  in  1  synchronous clear of overflow and drop_cnt only
- out_valid  out  1  FIFO head entry is available
- out_ready  in  1  consumer accepts the head entry this cycle
- out_data  out  32  a0 value of the head entry
- out_ts  out  TS_W  timestamp of the head entry
- level  out  $clog2(DEPTH)+1  number of occupied entries
- overflow  out  1  sticky: at least one event was dropped
- drop_cnt  out  DROP_W  number of dropped events, saturating

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FIFO emptied; out_valid=0, level=0, overflow=0, drop_cnt=0.
  - ts counter=0; last-value register=0; first flag=1.
  - out_data/out_ts=0.
  - Reset mid-stream discards all queued entries; no partial pop is completed.
- Timestamp: free-running counter, +1 every cycle after reset, wraps 2^TS_W-1 -> 0. It counts regardless of en.
- Event generation (only when en=1): event = first | (a0 != last).
  - On an event: last <= a0 and first <= 0.
  - The entry pushed is {a0, ts}, where ts is the counter value in that same cycle.
- en=0: last and first are held, so on re-enable a value that differs from the last captured one produces an event.
- Push/pop:
  - pop = out_valid & out_ready.
  - An event pushes if the FIFO is not full, or if pop is asserted in the same cycle.
  - Empty and push: entry is visible on out_valid/out_data the next cycle (1-cycle latency, no bypass).
  - Full and push with pop: both happen; level is unchanged and the pushed entry goes to the tail.
  - Full and push without pop: the event is dropped. overflow <= 1; drop_cnt += 1, saturating at 2^DROP_W-1. last is still updated, so the same value is not re-reported.
  - Pop when empty is impossible because out_valid=0.
  - level reflects the register state and updates on the cycle after a push/pop.
- out_valid/out_data/out_ts: the FIFO head, driven combinationally from registered storage. Values stay stable while out_valid=1 and out_ready=0.
- clr: clears overflow and drop_cnt. If clr and a drop occur in the same cycle, clr wins: overflow=0 and drop_cnt=0 afterwards. clr does not touch the FIFO, ts, or last.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is derived from level.
- No X on outputs after reset; storage contents beyond level are don't-care.

Test Plan:
- Reset, then en=1, a0=0 constant for 5 cycles, out_ready=1 -> exactly one entry {0, ts=0}; nothing further.
- a0 sequence 5,5,7,7,7,9 on consecutive cycles with out_ready=1 -> entries 5,7,9 with timestamps differing by 2 and 3.
- out_ready=0, a0 changing every cycle 1..10 with DEPTH=8 -> level=8; 2 values (9, 10) dropped; overflow=1; drop_cnt=2. Draining then yields 1..8 in order.
- FIFO full, simultaneous new value and out_ready=1 -> level stays 8; new value is at the tail; drop_cnt unchanged.
- clr asserted in the same cycle as a drop -> overflow=0 and drop_cnt=0 next cycle.
- Mid-stream rst_n=0 with level=4 -> next cycle level=0 and out_valid=0. First sample after reset is captured even if equal to the pre-reset value.
